// File: rtl/exe_stage_if.sv
// exe_stage_if: data SRAM request issued by the execute stage.
//   data_sram_en    : memory access enable
//   data_sram_we    : byte write enables
//   data_sram_addr  : byte address
//   data_sram_wdata : store data, replicated across byte lanes
// master = execute stage (drives the request), slave = memory side.
interface exe_stage_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  modport master (output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata);
  modport slave  (input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata);
endinterface

// File: rtl/exe_stage.sv
// exe_stage: execute stage of the 5-stage LoongArch pipeline.
// Registers the decode-to-execute bus, computes the ALU result or the
// load/store address, optionally runs a multi-cycle divider, drives the data
// SRAM request and produces the execute-to-mem and forwarding buses.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   flush          : exception flush, clears the stage
//   stall[5:0]     : stall vector from the stall controller (bit2 EX, bit3 MEM)
//   stallreq_es    : asks the stall controller to hold EX while dividing
//   ds_to_es_bus   : decode-to-execute bus (319b)
//   es_to_ms_bus   : execute-to-mem bus (271b)
//   es_to_ds_bus   : forwarding bus {is_load, reg_we, dest, es_result}
//   dsram          : data SRAM request (exe_stage_if.master)
//
// Configuration: define EXE_DIV_EN to build the radix-2 restoring divider.
// Without it divide instructions pass through in one cycle with result 0
// and stallreq_es is tied low.
module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = 319,
  parameter int ES_TO_MS_BUS_WD = 271,
  parameter int ES_TO_DS_BUS_WD = 39
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [5:0]                 stall,
  output logic                       stallreq_es,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_bus,
  exe_stage_if.master                dsram
);

  // ---------------- pipeline register ----------------
  logic [DS_TO_ES_BUS_WD-1:0] bus_q, bus_d;

  always_comb begin
    bus_d = bus_q;
    if (flush)                     bus_d = '0;
    else if (stall[2] && !stall[3]) bus_d = '0;  // EX held, MEM runs: bubble
    else if (!stall[2])             bus_d = ds_to_es_bus;
  end

  always_ff @(posedge clk) begin
    if (reset) bus_q <= '0;
    else       bus_q <= bus_d;
  end

  logic [63:0] csr_vec, csr_bus;
  logic [11:0] alu_op;
  logic [3:0]  div_op;
  logic [5:0]  load_op;
  logic [2:0]  store_op;
  logic        reg_we;
  logic [4:0]  dest;
  logic [31:0] src1, src2, rkd_value, pc, inst;

  assign {csr_vec, csr_bus, alu_op, div_op, load_op, store_op, reg_we, dest,
          src1, src2, rkd_value, pc, inst} = bus_q;

  // ---------------- ALU ----------------
  logic [31:0] alu_result;

  always_comb begin
    alu_result = '0;
    if      (alu_op[11]) alu_result = src1 + src2;
    else if (alu_op[10]) alu_result = src1 - src2;
    else if (alu_op[9])  alu_result = {31'b0, $signed(src1) < $signed(src2)};
    else if (alu_op[8])  alu_result = {31'b0, src1 < src2};
    else if (alu_op[7])  alu_result = src1 & src2;
    else if (alu_op[6])  alu_result = ~(src1 | src2);
    else if (alu_op[5])  alu_result = src1 | src2;
    else if (alu_op[4])  alu_result = src1 ^ src2;
    else if (alu_op[3])  alu_result = src1 << src2[4:0];
    else if (alu_op[2])  alu_result = src1 >> src2[4:0];
    else if (alu_op[1])  alu_result = $signed(src1) >>> src2[4:0];
    else if (alu_op[0])  alu_result = src2;
  end

  // ---------------- divider ----------------
  logic [31:0] div_result;

`ifdef EXE_DIV_EN
  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_e;

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;      // dividend shifts out, quotient shifts in
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsr_q, dsr_d;      // divisor magnitude
  logic        qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic        fresh_q, fresh_d;  // register holds an instruction not yet started
  logic        div_start, is_signed, is_mod;
  logic [31:0] a_abs, b_abs, q_fix, r_fix;
  logic [32:0] partial, diff;

  assign is_signed = div_op[3] | div_op[2];
  assign is_mod    = div_op[2] | div_op[0];
  assign a_abs     = (is_signed && src1[31]) ? -src1 : src1;
  assign b_abs     = (is_signed && src2[31]) ? -src2 : src2;
  assign div_start = (state_q == DIV_IDLE) && (|div_op) && fresh_q && !flush;
  assign partial   = {rem_q, quo_q[31]};
  assign diff      = partial - {1'b0, dsr_q};

  always_comb begin
    fresh_d = fresh_q;
    if (div_start) fresh_d = 1'b0;
    if (flush || (stall[2] && !stall[3])) fresh_d = 1'b0;
    else if (!stall[2])                   fresh_d = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    stallreq_es = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (div_start) begin
          state_d     = DIV_CALC;
          cnt_d       = '0;
          quo_d       = a_abs;
          rem_d       = '0;
          dsr_d       = b_abs;
          qneg_d      = is_signed && (src1[31] ^ src2[31]);
          rneg_d      = is_signed && src1[31];
          dz_d        = (src2 == '0);
          stallreq_es = 1'b1;
        end
      end
      DIV_CALC: begin
        stallreq_es = 1'b1;
        // diff[32] is the borrow: partial remainder smaller than divisor
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = partial[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (!stall[2]) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (flush) state_d = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      fresh_q <= fresh_d;
    end
  end

  // Divide by zero keeps the all-ones quotient regardless of signs.
  assign q_fix      = (qneg_q && !dz_q) ? -quo_q : quo_q;
  assign r_fix      = rneg_q ? -rem_q : rem_q;
  assign div_result = is_mod ? r_fix : q_fix;
`else
  assign div_result  = '0;
  assign stallreq_es = 1'b0;
`endif

  // ---------------- result / buses ----------------
  logic [31:0] es_result;
  assign es_result = (|div_op) ? div_result : alu_result;

  assign es_to_ms_bus = {csr_vec, csr_bus, load_op, store_op, reg_we, dest,
                         es_result, src1, pc, inst};
  assign es_to_ds_bus = {|load_op, reg_we, dest, es_result};

  // ---------------- data SRAM ----------------
  logic [3:0]  we_raw;
  logic [31:0] wdata;

  always_comb begin
    we_raw = 4'b0000;
    wdata  = rkd_value;
    if (store_op[2]) begin
      we_raw = 4'b0001 << es_result[1:0];
      wdata  = {4{rkd_value[7:0]}};
    end else if (store_op[1]) begin
      we_raw = es_result[1] ? 4'b1100 : 4'b0011;
      wdata  = {2{rkd_value[15:0]}};
    end else if (store_op[0]) begin
      we_raw = 4'b1111;
    end
  end

  assign dsram.data_sram_en    = ((|load_op) | (|store_op)) & ~flush;
  assign dsram.data_sram_we    = (flush || stallreq_es) ? 4'b0000 : we_raw;
  assign dsram.data_sram_addr  = es_result;
  assign dsram.data_sram_wdata = wdata;

  logic unused_stall;
  assign unused_stall = ^{stall[5:4], stall[1:0]};

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage LoongArch pipeline, between the decode stage and mem_stage.
- Registers the decode-to-execute bus and computes the ALU result or the load/store address.
- Runs a multi-cycle divider, drives the data SRAM request, and produces es_to_ms_bus (271 bits) and a forwarding bus back to decode.
- Holds the pipeline through the stall controller while a divide is in progress.

Parameters:
DS_TO_ES_BUS_WD, 319, width of decode-to-execute bus
ES_TO_MS_BUS_WD, 271, width of execute-to-mem bus
ES_TO_DS_BUS_WD, 39, width of forwarding bus {is_load, reg_we, dest, es_result}

Ports:
clk  input  1  clock; one clock domain
reset  input  1  synchronous, active-high reset
flush  input  1  exception flush; clears stage
stall  input  6  pipeline stall vector; bit 2 = EX, bit 3 = MEM
stallreq_es  output  1  stall request while the divider is busy
ds_to_es_bus  input  319  {csr_vec[64], csr_bus[64], alu_op[12], div_op[4], load_op[6], store_op[3], reg_we, dest[5], src1[32], src2[32], rkd_value[32], pc[32], inst[32]}
es_to_ms_bus  output  271  {csr_vec, csr_bus, load_op, store_op, reg_we, dest, es_result, src1, pc, inst}
es_to_ds_bus  output  39  forwarding {|load_op, reg_we, dest, es_result}
data_sram_en  output  1  memory access enable
data_sram_we  output  4  byte write enables
data_sram_addr  output  32  byte address
data_sram_wdata  output  32  replicated store data

Behaviour:
- Pipeline register ds_to_es_bus_r, updated in priority order:
  - reset → 0
  - flush → 0
  - stall[2]&!stall[3] → 0 (bubble)
  - !stall[2] → ds_to_es_bus
  - otherwise hold
- An all-zero register is a bubble: reg_we=0, no SRAM access.
- alu_op one-hot, order MSB→LSB: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Shifts use src2[4:0].
  - lui result = src2.
  - slt/sltu return 0 or 1.
  - If no bit is set, result = 0.
- es_result:
  - |div_op → div_result.
  - Otherwise → alu_result.
  - For load/store, alu_op=add, so es_result = src1+src2 (the address).
- SRAM interface:
  - data_sram_en = |load_op | |store_op, forced to 0 when flush=1.
  - data_sram_addr = es_result.
  - store_op order {st.b, st.h, st.w}:
    - st.b: we = 4'b0001 << addr[1:0]; wdata = {4{rkd[7:0]}}.
    - st.h: we = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{rkd[15:0]}}.
    - st.w: we = 4'b1111; wdata = rkd.
  - data_sram_we = 0 when there is no store, when flush=1, or when stallreq_es=1.
- Divider:
  - div_op order {div.w, mod.w, div.wu, mod.wu}.
  - Radix-2 restoring, operating on magnitudes, with sign fix-up at the end.
  - FSM states:
    - IDLE → CALC when |div_op and the pipeline register holds a new instruction. Load operands; stallreq_es=1.
    - CALC: 32 iterations, one per cycle, counter 0..31; stallreq_es=1.
    - CALC → DONE after iteration 31. Result is latched; stallreq_es=0.
    - DONE → IDLE when !stall[2]. The instruction advances to MEM.
  - Latency: the divide is in EX at cycle T; stallreq_es is high for T..T+32 (33 cycles); the result is valid at T+33.
  - Back-to-back divides: DONE → IDLE → restart on the next latched instruction. No result reuse.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend; still 33 stall cycles.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - Remainder takes the sign of the dividend.
  - flush or reset in any state → IDLE next cycle; stallreq_es=0 next cycle; partial result discarded.
- Outputs at reset: stallreq_es=0, all buses 0, data_sram_en=0, data_sram_we=0.

Optional Feature:
- Macro EXE_DIV_EN.
- Defined: divider FSM as described.
- Undefined:
  - No divider logic; div_result = 0.
  - stallreq_es is tied to 0.
  - Divide instructions pass through in one cycle with es_result = 0.

Test Plan:
- add: src1=5, src2=0xFFFFFFFD → es_result 0x00000002, reg_we forwarded, no SRAM access.
- st.b: src1+src2=0x1003, rkd=0x12345678 → data_sram_en=1, we=4'b1000, wdata=0x78787878; st.h at 0x1002 → we=4'b1100, wdata=0x56785678.
- div.w: src1=-7, src2=2 → stallreq_es high exactly 33 cycles, es_result 0xFFFFFFFD; mod.w on the same operands → 0xFFFFFFFF.
- div.wu by 0: src1=0x10 → quotient 0xFFFFFFFF; mod.wu → 0x10; div.w 0x80000000/0xFFFFFFFF → 0x80000000.
- flush asserted at CALC iteration 10 → stallreq_es=0 next cycle, es_to_ms_bus=0; a following add completes normally.
- stall[2]=1 & stall[3]=0 with a load in decode → bubble inserted, es_to_ms_bus=0, data_sram_en=0; reset mid-divide → all outputs 0 the next cycle.
